// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO: a max-width pointer container,
// binary-to-gray encode, and the "top two bits inverted" full-compare pattern.
package async_fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    // Wide enough for any legal AW+1 pointer; callers zero-extend and size-cast back.
    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin_to_gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Gray pointer a full FIFO's write side must equal: read pointer with its two MSBs flipped.
    function automatic ptr_t full_cmp_ptr(input ptr_t g, input int unsigned w);
        ptr_t mask;
        mask = ptr_t'(3) << (w - 2);
        return g ^ mask;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Reset-to-zero multi-flop synchronizer for a gray-coded pointer crossing clock domains.
// Latency STAGES edges; no flow control, samples every edge.
module gray_ptr_sync #(
    parameter int unsigned W      = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] rq_q;
    logic [STAGES-1:0][W-1:0] rq_d;

    // Element 0 captures the asynchronous input; only the last element is safe to use.
    assign rq_d = {rq_q[STAGES-2:0], d_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_q <= '0;
        end else begin
            rq_q <= rq_d;
        end
    end

    assign q_o = rq_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wptr.sv
// Write-side pointer/flag stage: 1-cycle latency from winc, writes dropped while wfull.
// Optional registered almost-full output enabled by ASYNC_FIFO_WPTR_AFULL_EN.
module async_fifo_wptr
    import async_fifo_pkg::*;
#(
    parameter int unsigned AW          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          winc,
    input  logic [AW:0]   rptr_gray_async,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr_gray,
    output logic          wfull,
    output logic [AW:0]   wcount
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
    ,
    output logic          wafull
`endif
);

    localparam int unsigned PW = AW + 1;

    logic [AW:0] wbin_q,   wbin_d;
    logic [AW:0] wgray_q,  wgray_d;
    logic [AW:0] wcount_q, wcount_d;
    logic        wfull_q,  wfull_d;
    logic [AW:0] rq_s;
    logic [AW:0] rbin_s;
    logic        wpush;

    function automatic logic [AW:0] gray_to_bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = int'(AW) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    gray_ptr_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rptr_gray_async),
        .q_o   (rq_s)
    );

    // Write and read-pointer movement share one next-state computation; no priority.
    always_comb begin
        wpush    = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(wpush);
        wgray_d  = PW'(bin_to_gray(ptr_t'(wbin_d)));
        rbin_s   = gray_to_bin(rq_s);
        wcount_d = wbin_d - rbin_s;
        wfull_d  = (ptr_t'(wgray_d) == full_cmp_ptr(ptr_t'(rq_s), PW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
        end
    end

    assign waddr     = wbin_q[AW-1:0];
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;
    assign wcount    = wcount_q;

`ifdef ASYNC_FIFO_WPTR_AFULL_EN
    localparam logic [AW+1:0] DEPTH_X = {2'b01, {AW{1'b0}}};

    logic [AW+1:0] wfree_d;
    logic          wafull_q, wafull_d;

    // One extra bit so the free-slot count never wraps.
    always_comb begin
        wfree_d  = DEPTH_X - {1'b0, wcount_d};
        wafull_d = (wfree_d <= (AW+2)'(AF_THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull = wafull_q;
`endif

endmodule
